// File: rtl/out_port_arbiter.sv
// Output-port arbiter: round-robin over inject/thru/turn with packet lock
// and credit-based flow control toward the downstream buffer.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   inject_* / thru_* / turn_*
//                     requesters 0/1/2: flit, valid in; ready out
//   out_flit/out_valid registered output flit and its strobe
//   credit_in         downstream freed one slot (1-cycle pulse)
//   credit_err        sticky credit-overflow flag
module out_port_arbiter #(
    parameter int FLIT_W  = 82,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] inject_flit,
    input  logic              inject_valid,
    output logic              inject_ready,
    input  logic [FLIT_W-1:0] thru_flit,
    input  logic              thru_valid,
    output logic              thru_ready,
    input  logic [FLIT_W-1:0] turn_flit,
    input  logic              turn_valid,
    output logic              turn_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              credit_in,
    output logic              credit_err
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_owner;
    logic [1:0]        w_owner_nxt;
    logic [1:0]        r_last;
    logic [1:0]        w_last_nxt;
    logic [3:0]        r_credit;
    logic [3:0]        w_credit_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_out_valid;
    logic [FLIT_W-1:0] r_out_flit;

    logic [2:0]        w_valid;
    logic [1:0]        w_c1;
    logic [1:0]        w_c2;
    logic [1:0]        w_pick;
    logic [1:0]        w_gnt_idx;
    logic              w_gnt;
    logic [FLIT_W-1:0] w_sel_flit;
    logic              w_tail;

    // Requester index successor modulo 3.
    function automatic logic [1:0] f_next(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign w_valid = {turn_valid, thru_valid, inject_valid};

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_c1 = f_next(r_last);
        w_c2 = f_next(w_c1);
        if (w_valid[w_c1])
            w_pick = w_c1;
        else if (w_valid[w_c2])
            w_pick = w_c2;
        else
            w_pick = r_last;
    end

    always_comb begin
        w_gnt_idx = (r_state == ST_LOCKED) ? r_owner : w_pick;
        w_gnt     = 1'b0;
        if (!rst && (r_credit != 4'd0)) begin
            if (r_state == ST_LOCKED)
                w_gnt = w_valid[r_owner];
            else
                w_gnt = |w_valid;
        end
    end

    assign inject_ready = w_gnt && (w_gnt_idx == 2'd0);
    assign thru_ready   = w_gnt && (w_gnt_idx == 2'd1);
    assign turn_ready   = w_gnt && (w_gnt_idx == 2'd2);

    always_comb begin
        unique case (w_gnt_idx)
            2'd0:    w_sel_flit = inject_flit;
            2'd1:    w_sel_flit = thru_flit;
            default: w_sel_flit = turn_flit;
        endcase
    end

    assign w_tail = w_sel_flit[FLIT_W-2];

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt) begin
                    w_last_nxt = w_gnt_idx;
                    if (!w_tail) begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_gnt_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_gnt && w_tail)
                    w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A simultaneous transfer and credit return cancel out.
    always_comb begin
        w_credit_nxt = r_credit;
        w_err_nxt    = r_err;
        if (w_gnt && !credit_in) begin
            w_credit_nxt = r_credit - 4'd1;
        end else if (!w_gnt && credit_in) begin
            if (r_credit == CRED_MAX)
                w_err_nxt = 1'b1;
            else
                w_credit_nxt = r_credit + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 2'd0;
            r_last      <= 2'd2;
            r_credit    <= CRED_MAX;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_credit    <= w_credit_nxt;
            r_err       <= w_err_nxt;
            r_out_valid <= w_gnt;
            if (w_gnt)
                r_out_flit <= w_sel_flit;
        end
    end

    assign out_flit   = r_out_flit;
    assign out_valid  = r_out_valid;
    assign credit_err = r_err;

endmodule
